// File: rtl/inst_fetch_if.sv
//==============================================================================
// Module      : inst_fetch_if
// Description : Fetch-stage bundle. It carries the downstream accept and
//               redirect inputs, the instruction memory request/response
//               pair, and the IF/ID presentation outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface inst_fetch_if;
    logic        EN;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_IF;
    logic [31:0] inst_IF;
    logic        valid_IF;

    // The fetch unit drives the memory request and the IF/ID outputs.
    modport master (
        input  EN, redirect, redirect_pc, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, PC_IF, inst_IF, valid_IF
    );

    // The pipeline and memory side of the fetch unit.
    modport slave (
        output EN, redirect, redirect_pc, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, PC_IF, inst_IF, valid_IF
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
//==============================================================================
// Module      : inst_fetch
// Description : Single-outstanding instruction fetch unit. It issues one
//               memory request, waits for the response, and holds the
//               instruction until downstream accepts it. A redirect restarts
//               fetch and marks any in-flight response as stale.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic       clk,
    input  wire logic       rst,
    inst_fetch_if.master    fe
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] hold_pc_q;
    logic [31:0] hold_inst_q;
    logic        valid_q;
    logic        drop_q;    // one stale response is still in flight

    logic [31:0] seq_pc_d;
    logic [31:0] redirect_pc_d;

    // Sequential successor wraps naturally at 2^32.
    assign seq_pc_d      = hold_pc_q + 32'd4;
    assign redirect_pc_d = {fe.redirect_pc[31:2], 2'b00};

    // Fetch control: redirect outranks every other event in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= {RESET_PC[31:2], 2'b00};
            hold_pc_q   <= 32'h0000_0000;
            hold_inst_q <= NOP_INST;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else if (fe.redirect) begin
            fetch_pc_q <= redirect_pc_d;
            valid_q    <= 1'b0;
            case (state_q)
                S_REQ: begin
                    // The request issued this cycle targets the old path.
                    drop_q  <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fe.imem_rvalid) begin
                        // Outstanding response lands now and is discarded.
                        drop_q  <= 1'b0;
                        state_q <= S_REQ;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fe.imem_rvalid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            hold_pc_q   <= fetch_pc_q;
                            hold_inst_q <= fe.imem_rdata;
                            valid_q     <= 1'b1;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (fe.EN) begin
                        fetch_pc_q <= seq_pc_d;
                        valid_q    <= 1'b0;
                        state_q    <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // Request strobe is suppressed during reset so nothing escapes early.
    assign fe.imem_req  = (state_q == S_REQ) && !rst;
    assign fe.imem_addr = {fetch_pc_q[31:2], 2'b00};
    assign fe.PC_IF     = hold_pc_q;
    assign fe.inst_IF   = valid_q ? hold_inst_q : NOP_INST;
    assign fe.valid_IF  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
//==============================================================================
// Module      : tb_inst_fetch
// Description : Directed-vector bench for inst_fetch with a variable-latency
//               instruction memory model (rdata = addr + 32'h1000_0000).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_fetch;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    inst_fetch_if ifc ();

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (C_NOP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .fe  (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: request seen at cycle k answers in cycle k+mem_lat.
    int          mem_lat = 1;
    int          mem_cnt;
    bit          mem_pend;
    logic [31:0] mem_addr;

    initial begin
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = 32'h0;
        mem_pend        = 1'b0;
        mem_cnt         = 0;
        mem_addr        = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_pend = 1'b0;
            end else if (ifc.imem_req) begin
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = ifc.imem_addr;
            end
            @(posedge clk);
            #1;
            ifc.imem_rvalid = 1'b0;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    ifc.imem_rvalid = 1'b1;
                    ifc.imem_rdata  = mem_addr + 32'h1000_0000;
                    mem_pend        = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic        en;
        logic        rd;
        logic [31:0] rpc;
        logic        r;
        int          lat;   // 0 = leave memory latency unchanged
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vq[$];

    task automatic row(input logic en, input logic rd, input logic [31:0] rpc, input logic r,
                       input int lat, input logic req, input logic [31:0] addr,
                       input logic v, input logic [31:0] pc, input logic [31:0] inst);
        vec_t t;
        t.en = en; t.rd = rd; t.rpc = rpc; t.r = r; t.lat = lat;
        t.req = req; t.addr = addr; t.v = v; t.pc = pc; t.inst = inst;
        vq.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        ifc.EN          = 1'b0;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'h0;

        //   en rd rpc           r  lat req addr           v  pc             inst
        // Streaming, 1-cycle memory, EN held high
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0000, 0, 32'h0,         C_NOP);        // c0
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c1
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         1, 32'h0000_0000, 32'h1000_0000);// c2
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0004, 0, 32'h0,         C_NOP);        // c3
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c4
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         1, 32'h0000_0004, 32'h1000_0004);// c5
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0008, 0, 32'h0,         C_NOP);        // c6
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c7
        // Stall in HOLD for five cycles, then accept
        for (int k = 0; k < 5; k++)
            row(0, 0, 32'h0,     0, 0,  0, 32'h0,         1, 32'h0000_0008, 32'h1000_0008);// c8-c12
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         1, 32'h0000_0008, 32'h1000_0008);// c13
        // Redirect while waiting on a 3-cycle memory
        row(1, 0, 32'h0,         0, 3,  1, 32'h0000_000C, 0, 32'h0,         C_NOP);        // c14
        row(1, 1, 32'h0000_0102, 0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c15
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c16
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c17
        row(1, 0, 32'h0,         0, 1,  1, 32'h0000_0100, 0, 32'h0,         C_NOP);        // c18
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c19
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         1, 32'h0000_0100, 32'h1000_0100);// c20
        // Redirect coinciding with the response
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0104, 0, 32'h0,         C_NOP);        // c21
        row(1, 1, 32'h0000_0200, 0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c22
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0200, 0, 32'h0,         C_NOP);        // c23
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c24
        // Redirect in HOLD with EN=1, unaligned target, then wrap at 2^32
        row(1, 1, 32'hFFFF_FFFE, 0, 0,  0, 32'h0,         1, 32'h0000_0200, 32'h1000_0200);// c25
        row(1, 0, 32'h0,         0, 0,  1, 32'hFFFF_FFFC, 0, 32'h0,         C_NOP);        // c26
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c27
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0FFF_FFFC);// c28
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0000, 0, 32'h0,         C_NOP);        // c29
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c30
        // Reset asserted in HOLD with EN=1
        row(1, 0, 32'h0,         1, 0,  0, 32'h0,         1, 32'h0000_0000, 32'h1000_0000);// c31
        row(1, 0, 32'h0,         1, 0,  0, 32'h0,         0, 32'h0000_0000, C_NOP);        // c32
        row(1, 0, 32'h0,         0, 0,  1, 32'h0000_0000, 0, 32'h0,         C_NOP);        // c33
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         C_NOP);        // c34
        row(1, 0, 32'h0,         0, 0,  0, 32'h0,         1, 32'h0000_0000, 32'h1000_0000);// c35

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst imem_req", {31'h0, ifc.imem_req}, 32'h0);
        check_eq("rst valid_IF", {31'h0, ifc.valid_IF}, 32'h0);
        check_eq("rst inst_IF",  ifc.inst_IF, C_NOP);
        check_eq("rst PC_IF",    ifc.PC_IF, 32'h0);

        foreach (vq[i]) begin
            if (vq[i].lat != 0) mem_lat = vq[i].lat;
            @(posedge clk);
            #1;
            ifc.EN          = vq[i].en;
            ifc.redirect    = vq[i].rd;
            ifc.redirect_pc = vq[i].rpc;
            rst             = vq[i].r;
            @(negedge clk);
            check_eq($sformatf("c%0d imem_req", i), {31'h0, ifc.imem_req}, {31'h0, vq[i].req});
            if (vq[i].req)
                check_eq($sformatf("c%0d imem_addr", i), ifc.imem_addr, vq[i].addr);
            check_eq($sformatf("c%0d valid_IF", i), {31'h0, ifc.valid_IF}, {31'h0, vq[i].v});
            check_eq($sformatf("c%0d inst_IF", i), ifc.inst_IF, vq[i].inst);
            if (vq[i].v || vq[i].r)
                check_eq($sformatf("c%0d PC_IF", i), ifc.PC_IF, vq[i].pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
